// File: rtl/prog_delay_line.sv
// prog_delay_line: multi-channel delay line with a run-time delay setting and a flush/settle FSM.
// Optional feature: define PROG_DELAY_LINE_CLR_DATA_EN to zero data on reset/flush and gate out_data.
module prog_delay_line #(
    parameter int WIDTH         = 8,
    parameter int NUM_CH        = 4,
    parameter int MAX_DELAY     = 8,
    parameter int DEFAULT_DELAY = 4,
    localparam int DW           = $clog2(MAX_DELAY + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [DW-1:0]           delay_sel,
    input  logic                    in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic [DW-1:0]           delay_cur,
    output logic                    busy
);

    localparam int TW = NUM_CH * WIDTH;
    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] SETTLE = 1'b1;
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
    localparam logic [DW-1:0] DEF_D = DW'(DEFAULT_DELAY);

    logic [0:0]    state_reg;
    logic [DW-1:0] cnt_reg;
    logic [DW-1:0] delay_cur_reg;
    logic [DW-1:0] sel_clamped;
    logic          flush;
    logic          stage_valid [MAX_DELAY];
    logic [TW-1:0] stage_data  [MAX_DELAY];
    logic          sel_valid;
    logic [TW-1:0] sel_data;

    assign sel_clamped = (delay_sel > MAX_D) ? MAX_D : delay_sel;
    // Any change of the requested delay flushes, regardless of en or state.
    assign flush       = (sel_clamped != delay_cur_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= RUN;
            cnt_reg       <= '0;
            delay_cur_reg <= DEF_D;
        end else if (flush) begin
            delay_cur_reg <= sel_clamped;
            cnt_reg       <= sel_clamped;
            state_reg     <= (sel_clamped == '0) ? RUN : SETTLE;
        end else if (en && state_reg == SETTLE) begin
            cnt_reg <= cnt_reg - DW'(1);
            if (cnt_reg == DW'(1)) begin
                state_reg <= RUN;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_DELAY; gi++) begin : g_stage
            logic          valid_reg;
            logic [TW-1:0] data_reg;
            logic          prev_valid;
            logic [TW-1:0] prev_data;

            if (gi == 0) begin : g_head
                assign prev_valid = in_valid;
                assign prev_data  = in_data;
            end else begin : g_tail
                assign prev_valid = stage_valid[gi-1];
                assign prev_data  = stage_data[gi-1];
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    valid_reg <= 1'b0;
                end else if (flush) begin
                    valid_reg <= 1'b0;
                end else if (en) begin
                    valid_reg <= prev_valid;
                end
            end

`ifdef PROG_DELAY_LINE_CLR_DATA_EN
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    data_reg <= '0;
                end else if (flush) begin
                    data_reg <= '0;
                end else if (en) begin
                    data_reg <= prev_data;
                end
            end
`else
            // Data carries no reset; only the valid bits qualify it.
            always_ff @(posedge clk) begin
                if (en && !flush) begin
                    data_reg <= prev_data;
                end
            end
`endif

            assign stage_valid[gi] = valid_reg;
            assign stage_data[gi]  = data_reg;
        end
    endgenerate

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (delay_cur_reg == DW'(i + 1)) begin
                sel_valid = stage_valid[i];
                sel_data  = stage_data[i];
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        if (delay_cur_reg == '0) begin
            out_valid = in_valid;
            out_data  = in_data;
        end else begin
            out_valid = sel_valid && (state_reg == RUN);
`ifdef PROG_DELAY_LINE_CLR_DATA_EN
            out_data  = out_valid ? sel_data : '0;
`else
            out_data  = sel_data;
`endif
        end
    end

    assign delay_cur = delay_cur_reg;
    assign busy      = (state_reg == SETTLE);

endmodule

// File: tb/tb_prog_delay_line.sv
// Scoreboard bench for prog_delay_line: stimulus pushes {data, due cycle}, a negedge monitor pops and compares.
// Build once with and once without PROG_DELAY_LINE_CLR_DATA_EN.
module tb_prog_delay_line;

    localparam int WIDTH         = 8;
    localparam int NUM_CH        = 4;
    localparam int MAX_DELAY     = 8;
    localparam int DEFAULT_DELAY = 4;
    localparam int DW            = $clog2(MAX_DELAY + 1);
    localparam int TW            = WIDTH * NUM_CH;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          en        = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] delay_sel = DW'(4);
    logic [TW-1:0] in_data   = '0;
    logic          out_valid;
    logic          busy;
    logic [DW-1:0] delay_cur;
    logic [TW-1:0] out_data;

    typedef struct packed {
        logic [TW-1:0] data;
        int            due;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   en_tab [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};

    prog_delay_line #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .MAX_DELAY(MAX_DELAY), .DEFAULT_DELAY(DEFAULT_DELAY)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .delay_sel(delay_sel),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .delay_cur(delay_cur), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [TW-1:0] d, input int lat);
        in_valid = v;
        in_data  = d;
        if (v && lat >= 0) exp_q.push_back('{data: d, due: cyc + lat});
    endtask

    function automatic logic [TW-1:0] mk(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // Monitor: every presented output must match the oldest expectation, on its due cycle.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: out_valid=1 data 0x%08h at cycle %0d, required no output", out_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e.data || cyc != mon_e.due) begin
                    n_fail++;
                    $display("FAIL sb_txn: got 0x%08h at cycle %0d, required 0x%08h at cycle %0d",
                             out_data, cyc, mon_e.data, mon_e.due);
                end else begin
                    $display("txn: 0x%08h at cycle %0d", out_data, cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_delay_cur", delay_cur, DEFAULT_DELAY);
        next();
        reset = 1'b1;
        en    = 1'b1;

        // Default delay 4, identical data on every channel
        drive(1, {4{8'h11}}, 4); next();
        drive(1, {4{8'h22}}, 4); next();
        drive(1, {4{8'h33}}, 4); next();
        drive(0, '0, -1);
        repeat (6) next();

        // 4 -> 2 mid-stream: pre-flush samples are dropped
        drive(1, mk(8'h40), -1); next();
        drive(1, mk(8'h44), -1); next();
        delay_sel = DW'(2);
        drive(1, mk(8'h48), -1);
        @(negedge clk); check("b_busy_pre", busy, 0); next();
        drive(1, mk(8'h50), 2);
        @(negedge clk);
        check("b_busy_s0", busy, 1);
        check("b_out_valid_s0", out_valid, 0);
        check("b_delay_cur", delay_cur, 2);
        next();
        drive(1, mk(8'h54), 2);
        @(negedge clk);
        check("b_busy_s1", busy, 1);
        check("b_out_valid_s1", out_valid, 0);
        next();
        drive(1, mk(8'h58), 2);
        @(negedge clk); check("b_busy_done", busy, 0); next();
        drive(0, '0, -1);
        repeat (4) next();

        // Delay 0: combinational pass-through, no settle
        delay_sel = DW'(0);
        next();
        @(negedge clk);
        check("c_busy", busy, 0);
        check("c_delay_cur", delay_cur, 0);
        next();
        for (int i = 0; i < 3; i++) begin
            drive(1, mk(8'h60 + 8'(4 * i)), 0);
            @(negedge clk);
            check("c_pass_data", out_data, mk(8'h60 + 8'(4 * i)));
            check("c_pass_valid", out_valid, 1);
            next();
        end
        drive(0, mk(8'h70), -1);
        @(negedge clk); check("c_pass_invalid", out_valid, 0); next();

        // Clamp 15 -> 8, en gaps freeze the settle counter
        delay_sel = DW'(15);
        drive(0, '0, -1);
        next();
        for (int i = 0; i < 10; i++) begin
            en = en_tab[i];
            if (i == 0) drive(1, mk(8'h80), 10);
            else        drive(0, '0, -1);
            @(negedge clk);
            check("d_busy", busy, 1);
            check("d_out_valid", out_valid, 0);
            if (i == 0) check("d_delay_cur", delay_cur, MAX_DELAY);
`ifdef PROG_DELAY_LINE_CLR_DATA_EN
            check("d_clr_data", out_data, 0);
`endif
            next();
        end
        en = 1'b1;
        drive(1, mk(8'h90), 8);
        @(negedge clk); check("d_busy_done", busy, 0); next();
        drive(0, '0, -1);
        repeat (9) next();

        // Async reset mid-stream with valid stages
        for (int i = 0; i < 9; i++) begin
            drive(1, mk(8'hA0 + 8'(i)), (i == 0) ? 8 : -1);
            next();
        end
        check("e_valid_before_reset", out_valid, 1);
        drive(0, '0, -1);
        #1 reset = 1'b0;
        #1;
        check("e_rst_out_valid", out_valid, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_delay_cur", delay_cur, DEFAULT_DELAY);
        next();
        reset = 1'b1;
        next();
        next();
        next();
        // Async reset mid-settle
        check("e_busy_settle", busy, 1);
        #1 reset = 1'b0;
        #1;
        check("e_rst2_out_valid", out_valid, 0);
        check("e_rst2_busy", busy, 0);
        check("e_rst2_delay_cur", delay_cur, DEFAULT_DELAY);
        delay_sel = DW'(4);
        next();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, mk(8'hC0 + 8'(4 * i)), 4);
            next();
        end
        drive(0, '0, -1);
        repeat (6) next();

        check("sb_drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
